// File: rtl/lcd_pkg.sv
// Shared HD44780 command bytes, screen strings, FSM/sequence types and ASCII helpers
// for the character-LCD controller.
package lcd_pkg;

  localparam logic [7:0] CMD_CLEAR     = 8'h01;
  localparam logic [7:0] CMD_HOME      = 8'h02;
  localparam logic [7:0] CMD_ENTRY     = 8'h06;
  localparam logic [7:0] CMD_DISP_OFF  = 8'h08;
  localparam logic [7:0] CMD_DISP_ON   = 8'h0C;
  localparam logic [7:0] CMD_FUNC_8B2L = 8'h38;
  localparam logic [7:0] CMD_LINE1     = 8'h80;
  localparam logic [7:0] CMD_LINE2     = 8'hC0;

  localparam logic [127:0] SPLASH_L1 = "   MINI  CPU    ";
  localparam logic [127:0] SPLASH_L2 = "    READY...    ";

  typedef enum logic [3:0] {
    INIT_WAIT, INIT_CMD, IDLE, LOAD_SEQ, BYTE_SETUP, BYTE_EN, BYTE_HOLD, BYTE_WAIT, NEXT
  } lcd_state_t;

  typedef enum logic [1:0] {SEQ_INIT, SEQ_BLANK, SEQ_SPLASH, SEQ_NORMAL} seq_kind_t;

  function automatic logic [55:0] mnemonic(input logic [2:0] op);
    case (op)
      3'd0:    return "LOAD   ";
      3'd1:    return "ADD    ";
      3'd2:    return "ADDI   ";
      3'd3:    return "SUB    ";
      3'd4:    return "SUBI   ";
      3'd5:    return "MUL    ";
      3'd6:    return "CLEAR  ";
      default: return "DISPLAY";
    endcase
  endfunction

  function automatic logic [7:0] digit_ascii(input logic [3:0] d);
    return 8'h30 + {4'h0, d};
  endfunction

  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? 8'h30 + {4'h0, n} : 8'h37 + {4'h0, n};
  endfunction

  function automatic logic [7:0] str_char(input logic [127:0] s, input logic [3:0] pos);
    return s[8*(15-int'(pos)) +: 8];
  endfunction

endpackage

// File: rtl/lcd_bin2bcd.sv
// Sequential double-dabble: 16-bit binary to 5 BCD digits; done_o rises 17 cycles
// after start_i and stays high until the next start.
module lcd_bin2bcd (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start_i,
  input  logic [15:0] bin_i,
  output logic        done_o,
  output logic [19:0] bcd_o
);
  logic [15:0] bin_q, bin_d;
  logic [19:0] bcd_q, bcd_d, adj;
  logic [4:0]  cnt_q, cnt_d;
  logic        run_q, run_d, done_q, done_d;

  always_comb begin
    adj = bcd_q;
    for (int k = 0; k < 5; k++) begin
      if (bcd_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = bcd_q[4*k +: 4] + 4'd3;
    end
    bin_d  = bin_q;
    bcd_d  = bcd_q;
    cnt_d  = cnt_q;
    run_d  = run_q;
    done_d = done_q;
    if (start_i) begin
      bin_d  = bin_i;
      bcd_d  = '0;
      cnt_d  = 5'd16;
      run_d  = 1'b1;
      done_d = 1'b0;
    end else if (run_q) begin
      if (cnt_q != 5'd0) begin
        {bcd_d, bin_d} = {adj[18:0], bin_q, 1'b0};
        cnt_d = cnt_q - 5'd1;
      end else begin
        run_d  = 1'b0;
        done_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bin_q  <= '0;
      bcd_q  <= '0;
      cnt_q  <= '0;
      run_q  <= 1'b0;
      done_q <= 1'b0;
    end else begin
      bin_q  <= bin_d;
      bcd_q  <= bcd_d;
      cnt_q  <= cnt_d;
      run_q  <= run_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;
  assign bcd_o  = bcd_q;
endmodule

// File: rtl/lcd_display_controller.sv
// HD44780 16x2 controller: power-up init, splash, blank/off and two-line result screen.
// Define LCD_HEX_VALUE_EN to show the value as 0xHHHH instead of signed decimal.
module lcd_display_controller
  import lcd_pkg::*;
#(
  parameter int T_POWERUP_CYC = 750000,
  parameter int T_EN_CYC      = 25,
  parameter int T_CMD_CYC     = 2500,
  parameter int T_CLEAR_CYC   = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        lcd_start,
  input  logic [2:0]  lcd_opcode,
  input  logic [3:0]  lcd_reg_index,
  input  logic [15:0] lcd_value,
  input  logic        show_splash_req,
  input  logic        force_blank_req,
  output logic        lcd_busy,
  output logic [7:0]  lcd_data,
  output logic        lcd_rs,
  output logic        lcd_rw,
  output logic        lcd_en,
  output logic        lcd_on
);
  lcd_state_t  state_q, state_d;
  seq_kind_t   kind_q, kind_d;
  logic [31:0] cnt_q, cnt_d, wait_lim;
  logic [5:0]  idx_q, idx_d, last_idx, j;
  logic        pre_q, pre_d, on_q, on_d, rs_q, rs_d, en_q;
  logic [7:0]  data_q, data_d, byte_dat, ln1, ln2;
  logic [2:0]  opcode_q, opcode_d;
  logic [3:0]  reg_q, reg_d, p1, p2, units;
  logic [15:0] value_q, value_d;
  logic        splash_q, splash_d, blank_q, blank_d;
  logic        byte_rs, ld, bcd_start, bcd_done;
  logic [63:0] mn_pad;

  localparam logic [31:0] EN_LAST = 32'(T_EN_CYC - 1);

`ifdef LCD_HEX_VALUE_EN
  assign bcd_done = 1'b1;
`else
  logic [19:0] bcd;
  lcd_bin2bcd u_bcd (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (bcd_start),
    .bin_i   (value_q[15] ? (~value_q + 16'd1) : value_q),
    .done_o  (bcd_done),
    .bcd_o   (bcd)
  );
`endif

  always_comb begin
    case (kind_q)
      SEQ_INIT:   last_idx = 6'd3;
      SEQ_BLANK:  last_idx = 6'd1;
      SEQ_SPLASH: last_idx = 6'd34;
      default:    last_idx = 6'd33;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 32'd1;
    kind_d    = kind_q;
    idx_d     = idx_q;
    pre_d     = pre_q;
    on_d      = on_q;
    opcode_d  = opcode_q;
    reg_d     = reg_q;
    value_d   = value_q;
    splash_d  = splash_q;
    blank_d   = blank_q;
    bcd_start = 1'b0;
    wait_lim  = (!rs_q && (data_q == CMD_CLEAR || data_q == CMD_HOME)) ?
                32'(T_CLEAR_CYC) : 32'(T_CMD_CYC);
    case (state_q)
      INIT_WAIT:  if (cnt_q == 32'(T_POWERUP_CYC - 1)) state_d = INIT_CMD;
      INIT_CMD: begin
        kind_d  = SEQ_INIT;
        idx_d   = '0;
        pre_d   = 1'b0;
        state_d = BYTE_SETUP;
      end
      IDLE: if (lcd_start) begin
        opcode_d = lcd_opcode;
        reg_d    = lcd_reg_index;
        value_d  = lcd_value;
        splash_d = show_splash_req;
        blank_d  = force_blank_req;
        state_d  = LOAD_SEQ;
      end
      LOAD_SEQ: begin
        kind_d    = blank_q ? SEQ_BLANK : (splash_q ? SEQ_SPLASH : SEQ_NORMAL);
        idx_d     = '0;
        pre_d     = !on_q;
        on_d      = 1'b1;
        bcd_start = 1'b1;
        state_d   = BYTE_SETUP;
      end
      BYTE_SETUP: if (cnt_q == EN_LAST) state_d = BYTE_EN;
      BYTE_EN:    if (cnt_q == EN_LAST) state_d = BYTE_HOLD;
      BYTE_HOLD:  if (cnt_q == EN_LAST) state_d = BYTE_WAIT;
      BYTE_WAIT:  if (cnt_q == wait_lim - 32'd1) state_d = NEXT;
      NEXT: begin
        if (pre_q) begin
          pre_d   = 1'b0;
          state_d = BYTE_SETUP;
        end else if (idx_q == last_idx) begin
          state_d = IDLE;
          if (kind_q == SEQ_BLANK) on_d = 1'b0;
        // Result digits must be settled before any result-screen byte goes out.
        end else if (bcd_done || kind_q != SEQ_NORMAL) begin
          idx_d   = idx_q + 6'd1;
          state_d = BYTE_SETUP;
        end
      end
      default: state_d = INIT_WAIT;
    endcase
    if (state_d != state_q) cnt_d = '0;
  end

  // Byte for the slot being entered; splash has a leading clear, then shares the normal layout.
  always_comb begin
    j      = (kind_d == SEQ_SPLASH) ? idx_d - 6'd1 : idx_d;
    p1     = 4'(j - 6'd1);
    p2     = 4'(j - 6'd18);
    mn_pad = {mnemonic(opcode_q), 8'h20};
    units  = (reg_q >= 4'd10) ? reg_q - 4'd10 : reg_q;
    ln1    = 8'h20;
    ln2    = 8'h20;
    if (kind_d == SEQ_SPLASH) begin
      ln1 = str_char(SPLASH_L1, p1);
      ln2 = str_char(SPLASH_L2, p2);
    end else begin
      if (p1 < 4'd7)       ln1 = mn_pad[8*(7-int'(p1[2:0])) +: 8];
      else if (p1 == 4'd12) ln1 = "R";
      else if (p1 == 4'd13) ln1 = (reg_q >= 4'd10) ? "1" : "0";
      else if (p1 == 4'd14) ln1 = digit_ascii(units);
`ifdef LCD_HEX_VALUE_EN
      case (p2)
        4'd10:   ln2 = "0";
        4'd11:   ln2 = "x";
        4'd12:   ln2 = hex_ascii(value_q[15:12]);
        4'd13:   ln2 = hex_ascii(value_q[11:8]);
        4'd14:   ln2 = hex_ascii(value_q[7:4]);
        4'd15:   ln2 = hex_ascii(value_q[3:0]);
        default: ln2 = 8'h20;
      endcase
`else
      case (p2)
        4'd10:   ln2 = value_q[15] ? "-" : "+";
        4'd11:   ln2 = digit_ascii(bcd[19:16]);
        4'd12:   ln2 = digit_ascii(bcd[15:12]);
        4'd13:   ln2 = digit_ascii(bcd[11:8]);
        4'd14:   ln2 = digit_ascii(bcd[7:4]);
        4'd15:   ln2 = digit_ascii(bcd[3:0]);
        default: ln2 = 8'h20;
      endcase
`endif
    end
    byte_rs  = 1'b0;
    byte_dat = CMD_CLEAR;
    if (pre_d) begin
      byte_dat = CMD_DISP_ON;
    end else begin
      case (kind_d)
        SEQ_INIT: begin
          case (idx_d[1:0])
            2'd0:    byte_dat = CMD_FUNC_8B2L;
            2'd1:    byte_dat = CMD_DISP_ON;
            2'd2:    byte_dat = CMD_ENTRY;
            default: byte_dat = CMD_CLEAR;
          endcase
        end
        SEQ_BLANK: byte_dat = (idx_d == 6'd0) ? CMD_CLEAR : CMD_DISP_OFF;
        default: begin
          if (kind_d == SEQ_SPLASH && idx_d == 6'd0) byte_dat = CMD_CLEAR;
          else if (j == 6'd0)  byte_dat = CMD_LINE1;
          else if (j == 6'd17) byte_dat = CMD_LINE2;
          else begin
            byte_rs  = 1'b1;
            byte_dat = (j < 6'd17) ? ln1 : ln2;
          end
        end
      endcase
    end
    ld     = (state_d == BYTE_SETUP) && (state_q != BYTE_SETUP);
    data_d = ld ? byte_dat : data_q;
    rs_d   = ld ? byte_rs : rs_q;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= INIT_WAIT;
      kind_q   <= SEQ_INIT;
      cnt_q    <= '0;
      idx_q    <= '0;
      pre_q    <= 1'b0;
      on_q     <= 1'b1;
      rs_q     <= 1'b0;
      en_q     <= 1'b0;
      data_q   <= '0;
      opcode_q <= '0;
      reg_q    <= '0;
      value_q  <= '0;
      splash_q <= 1'b0;
      blank_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      kind_q   <= kind_d;
      cnt_q    <= cnt_d;
      idx_q    <= idx_d;
      pre_q    <= pre_d;
      on_q     <= on_d;
      rs_q     <= rs_d;
      en_q     <= (state_d == BYTE_EN);
      data_q   <= data_d;
      opcode_q <= opcode_d;
      reg_q    <= reg_d;
      value_q  <= value_d;
      splash_q <= splash_d;
      blank_q  <= blank_d;
    end
  end

  assign lcd_busy = (state_q != IDLE);
  assign lcd_data = data_q;
  assign lcd_rs   = rs_q;
  assign lcd_rw   = 1'b0;
  assign lcd_en   = en_q;
  assign lcd_on   = on_q;
endmodule

// File: tb/tb_lcd_display_controller.sv
// Self-checking bench: screen-level reference model, byte/timing monitor, random requests.
module tb_lcd_display_controller;
  localparam int T_PU = 20, T_EN = 2, T_CMD = 5, T_CLR = 10;

  logic clk = 1'b0, rst_n = 1'b0, lcd_start = 1'b0;
  logic [2:0] lcd_opcode = '0;
  logic [3:0] lcd_reg_index = '0;
  logic [15:0] lcd_value = '0;
  logic show_splash_req = 1'b0, force_blank_req = 1'b0;
  logic lcd_busy, lcd_rs, lcd_rw, lcd_en, lcd_on;
  logic [7:0] lcd_data;

  int errors = 0, checks = 0, cyc = 0, strobes = 0;
  logic [8:0] exp_q[$];
  bit model_on = 1'b1;
  logic [7:0] l1[16], l2[16];
  int line_sel = 0, col = 0;
  string mn_tab[8] = '{"LOAD", "ADD", "ADDI", "SUB", "SUBI", "MUL", "CLEAR", "DISPLAY"};

  lcd_display_controller #(.T_POWERUP_CYC(T_PU), .T_EN_CYC(T_EN), .T_CMD_CYC(T_CMD),
                           .T_CLEAR_CYC(T_CLR)) dut (
    .clk(clk), .rst_n(rst_n), .lcd_start(lcd_start), .lcd_opcode(lcd_opcode),
    .lcd_reg_index(lcd_reg_index), .lcd_value(lcd_value), .show_splash_req(show_splash_req),
    .force_blank_req(force_blank_req), .lcd_busy(lcd_busy), .lcd_data(lcd_data),
    .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_en(lcd_en), .lcd_on(lcd_on));

  always #5 clk = ~clk;

  task automatic chk_eq(input string name, input logic [63:0] act, input logic [63:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, expv);
    end
  endtask

  task automatic chk_ge(input string name, input int act, input int minv);
    checks++;
    if (act < minv) begin
      errors++;
      $display("FAIL %s: got %0d, required at least %0d", name, act, minv);
    end
  endtask

  task automatic chk_str(input string name, input string act, input string expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got \"%s\", required \"%s\"", name, act, expv);
    end
  endtask

  // ---------------- reference model: screens as strings ----------------
  function automatic string pad(input string s, input int n);
    string r = s;
    while (r.len() < n) r = {r, " "};
    return r;
  endfunction

  function automatic string model_l1(input int op, input int r);
    return {pad(mn_tab[op], 7), "     R", $sformatf("%02d", r), " "};
  endfunction

  function automatic string model_l2(input logic [15:0] v);
    int vi = int'(v);
`ifdef LCD_HEX_VALUE_EN
    string hx = "0123456789ABCDEF";
    string s = "          0x";
    for (int k = 3; k >= 0; k--) s = {s, $sformatf("%c", hx.getc((vi >> (4*k)) & 15))};
    return s;
`else
    int mag = (vi >= 32768) ? 65536 - vi : vi;
    return $sformatf("          %s%05d", (vi >= 32768) ? "-" : "+", mag);
`endif
  endfunction

  function automatic string line_str(input int which);
    string s = "";
    for (int i = 0; i < 16; i++) s = $sformatf("%s%c", s, (which == 1) ? l1[i] : l2[i]);
    return s;
  endfunction

  task automatic push_cmd(input logic [7:0] c);
    exp_q.push_back({1'b0, c});
  endtask

  task automatic push_str(input string s);
    logic [7:0] c;
    for (int i = 0; i < 16; i++) begin
      c = s.getc(i);
      exp_q.push_back({1'b1, c});
    end
  endtask

  // ---------------- monitor: strobes, stability, timing ----------------
  logic prev_en = 1'b0;
  logic [8:0] cap = '0, prev_bus = '0, bus;
  int stable = 0, hold_left = 0, en_len = 0, last_fall = -1, last_wait = 0;

  task automatic scr_write(input logic [8:0] b);
    if (b == 9'h080) begin line_sel = 1; col = 0; end
    else if (b == 9'h0C0) begin line_sel = 2; col = 0; end
    else if (b[8] && col < 16) begin
      if (line_sel == 1) l1[col] = b[7:0];
      else if (line_sel == 2) l2[col] = b[7:0];
      col++;
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    if (!rst_n) begin
      prev_en = 1'b0; hold_left = 0; last_fall = -1; stable = 0; prev_bus = '0; line_sel = 0;
    end else begin
      bus = {lcd_rs, lcd_data};
      chk_eq("rw_low", lcd_rw, 1'b0);
      if (exp_q.size() != 0) chk_eq("busy_active", lcd_busy, 1'b1);
      stable = (bus == prev_bus) ? stable + 1 : 1;
      if (lcd_en && !prev_en) begin
        cap = bus; en_len = 0; strobes++;
        chk_ge("setup_cycles", stable, T_EN + 1);
        if (last_fall >= 0) chk_ge("byte_gap", cyc - last_fall, 2*T_EN + last_wait);
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_strobe: got %03h, required no strobe", bus);
        end else chk_eq($sformatf("byte%0d", strobes), bus, exp_q.pop_front());
        scr_write(bus);
      end
      if (lcd_en) begin en_len++; chk_eq("en_stable", bus, cap); end
      if (!lcd_en && prev_en) begin
        chk_eq("en_width", en_len, T_EN);
        hold_left = T_EN; last_fall = cyc;
        last_wait = (cap == 9'h001 || cap == 9'h002) ? T_CLR : T_CMD;
      end
      if (hold_left > 0) begin chk_eq("hold_stable", bus, cap); hold_left--; end
      prev_en = lcd_en; prev_bus = bus;
    end
  end

  // ---------------- stimulus ----------------
  task automatic wait_idle(input string name);
    int n = 0;
    do begin @(negedge clk); n++; end while (lcd_busy && n < 3000);
    chk_eq({name, "_idle"}, lcd_busy, 1'b0);
    chk_eq({name, "_drained"}, exp_q.size(), 0);
  endtask

  task automatic do_init();
    int n = 0;
    int s0;
    @(negedge clk);
    rst_n = 1'b1;
    s0 = strobes;
    push_cmd(8'h38); push_cmd(8'h0C); push_cmd(8'h06); push_cmd(8'h01);
    model_on = 1'b1;
    chk_eq("busy_after_release", lcd_busy, 1'b1);
    while (!lcd_en && n < 200) begin @(negedge clk); n++; end
    chk_ge("powerup_delay", n, T_PU);
    wait_idle("init");
    chk_eq("init_strobes", strobes - s0, 4);
    chk_eq("init_on", lcd_on, 1'b1);
  endtask

  task automatic request(input logic [2:0] op, input logic [3:0] r, input logic [15:0] v,
                         input bit sp, input bit bl);
    @(negedge clk);
    lcd_opcode = op; lcd_reg_index = r; lcd_value = v;
    show_splash_req = sp; force_blank_req = bl; lcd_start = 1'b1;
    @(negedge clk);
    lcd_start = 1'b0;
    lcd_value = 16'($urandom); lcd_opcode = 3'($urandom); lcd_reg_index = 4'($urandom);
    show_splash_req = 1'($urandom); force_blank_req = 1'($urandom);
    chk_eq("busy_after_accept", lcd_busy, 1'b1);
    if (!model_on) push_cmd(8'h0C);
    if (bl) begin
      push_cmd(8'h01); push_cmd(8'h08);
      model_on = 1'b0;
    end else begin
      model_on = 1'b1;
      if (sp) begin
        push_cmd(8'h01); push_cmd(8'h80); push_str("   MINI  CPU    ");
        push_cmd(8'hC0); push_str("    READY...    ");
      end else begin
        push_cmd(8'h80); push_str(model_l1(int'(op), int'(r)));
        push_cmd(8'hC0); push_str(model_l2(v));
      end
    end
  endtask

  task automatic stray_start();
    repeat ($urandom_range(1, 60)) @(negedge clk);
    lcd_opcode = 3'($urandom); lcd_value = 16'($urandom);
    show_splash_req = 1'($urandom); force_blank_req = 1'($urandom);
    lcd_start = 1'b1;
    @(negedge clk);
    lcd_start = 1'b0;
  endtask

  initial begin
    int s0, n;
    logic [15:0] edges[4];
    logic [15:0] v;
    edges[0] = 16'h8000; edges[1] = 16'h7FFF; edges[2] = 16'hFFFF; edges[3] = 16'h0000;

    repeat (3) @(negedge clk);
    chk_eq("rst_busy", lcd_busy, 1'b1);
    chk_eq("rst_data", lcd_data, 8'h00);
    chk_eq("rst_rs", lcd_rs, 1'b0);
    chk_eq("rst_rw", lcd_rw, 1'b0);
    chk_eq("rst_en", lcd_en, 1'b0);
    chk_eq("rst_on", lcd_on, 1'b1);

    chk_str("pin_model_l1", model_l1(1, 5), "ADD         R05 ");
`ifdef LCD_HEX_VALUE_EN
    chk_str("pin_model_l2", model_l2(16'hFFFB), "          0xFFFB");
`else
    chk_str("pin_model_l2", model_l2(16'h8000), "          -32768");
`endif

    do_init();

    s0 = strobes;
    request(3'd1, 4'd5, 16'h0007, 1'b0, 1'b0);
    wait_idle("add7");
    chk_eq("add7_strobes", strobes - s0, 34);
    chk_str("add7_line1", line_str(1), "ADD         R05 ");
`ifdef LCD_HEX_VALUE_EN
    chk_str("add7_line2", line_str(2), "          0x0007");
`else
    chk_str("add7_line2", line_str(2), "          +00007");
`endif

    request(3'd3, 4'd15, 16'h8000, 1'b0, 1'b0);
    wait_idle("min");
    chk_str("min_line1", line_str(1), "SUB         R15 ");
`ifdef LCD_HEX_VALUE_EN
    chk_str("min_line2", line_str(2), "          0x8000");
`else
    chk_str("min_line2", line_str(2), "          -32768");
`endif

    request(3'd7, 4'd10, 16'hFFFB, 1'b0, 1'b0);
    wait_idle("neg5");
    chk_str("neg5_line1", line_str(1), "DISPLAY     R10 ");
`ifdef LCD_HEX_VALUE_EN
    chk_str("neg5_line2", line_str(2), "          0xFFFB");
`else
    chk_str("neg5_line2", line_str(2), "          -00005");
`endif

    s0 = strobes;
    request(3'd0, 4'd0, 16'h0000, 1'b1, 1'b1);
    wait_idle("blank");
    chk_eq("blank_strobes", strobes - s0, 2);
    chk_eq("blank_on", lcd_on, 1'b0);

    s0 = strobes;
    request(3'd2, 4'd9, 16'd1234, 1'b0, 1'b0);
    wait_idle("wake");
    chk_eq("wake_strobes", strobes - s0, 35);
    chk_eq("wake_on", lcd_on, 1'b1);

    request(3'd0, 4'd0, 16'h0000, 1'b1, 1'b0);
    stray_start();
    wait_idle("splash");
    chk_str("splash_line1", line_str(1), "   MINI  CPU    ");
    chk_str("splash_line2", line_str(2), "    READY...    ");

    for (int t = 0; t < 14; t++) begin
      v = ($urandom_range(0, 3) == 0) ? edges[$urandom_range(0, 3)] : 16'($urandom);
      request(3'($urandom), 4'($urandom), v, $urandom_range(0, 5) == 0, $urandom_range(0, 6) == 0);
      if (t % 2 == 0) stray_start();
      wait_idle($sformatf("rand%0d", t));
      chk_eq($sformatf("rand%0d_on", t), lcd_on, model_on);
    end

    request(3'd5, 4'd3, 16'h1234, 1'b0, 1'b0);
    stray_start();
    n = 0;
    while (!lcd_en && n < 200) begin @(negedge clk); n++; end
    chk_eq("midbyte_en_seen", lcd_en, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    chk_eq("midrst_en", lcd_en, 1'b0);
    chk_eq("midrst_busy", lcd_busy, 1'b1);
    chk_eq("midrst_data", lcd_data, 8'h00);
    chk_eq("midrst_on", lcd_on, 1'b1);
    exp_q.delete();
    repeat (2) @(negedge clk);
    do_init();

    request(3'd4, 4'd12, 16'd65, 1'b0, 1'b0);
    wait_idle("post_reset");
    chk_str("post_reset_line1", line_str(1), "SUBI        R12 ");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
